// File: rtl/qspi_ram_pkg.sv
// Shared definitions for the QPI SRAM emulator, the RAM controller and the bench:
// command opcodes and the emulator state enumeration.
package qspi_ram_pkg;

  localparam logic [7:0] CMD_READ_QUAD  = 8'h0B;
  localparam logic [7:0] CMD_WRITE_QUAD = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } qspiState_e;

  function automatic logic isKnownCmd(input logic [7:0] cmd);
    return (cmd == CMD_READ_QUAD) || (cmd == CMD_WRITE_QUAD);
  endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// Two-flop synchroniser for an asynchronous bus line plus a history flop that
// turns level changes into single-cycle rise/fall strobes.
module qspi_sync_edge
  import qspi_ram_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic last_q;

  // Stages reset low so a bus already selected at reset release does not look
  // like a fresh chip-select falling edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      last_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~last_q;
  assign fall_o = ~sync_q & last_q;

endmodule

// File: rtl/qspi_ram_emulator.sv
// QPI serial SRAM emulator: oversamples ram_clk/ram_cs_n/ram_io with clk_in and
// serves quad fast read (0x0B) and quad write (0x02) from an internal byte array.
module qspi_ram_emulator
  import qspi_ram_pkg::*;
#(
  parameter int    ADDR_W      = 24,
  parameter int    DEPTH_LOG2  = 12,
  parameter int    WAIT_CYCLES = 10,
  parameter string INIT_FILE   = ""
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       ram_clk,
  input  logic       ram_cs_n,
  input  logic [3:0] ram_io_in,
  output logic [3:0] ram_io_out,
  output logic       ram_io_oe,
  output logic       cmd_err,
  output logic       busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ADDR_NIBBLES = ADDR_W / 4;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic clkSync, clkRise, clkFall;
  logic csSync, csRise, csFall;
  logic unusedSync;

  qspi_sync_edge uClkSync (
    .clk_i   (clk_in),
    .rst_n_i (rst_n),
    .async_i (ram_clk),
    .sync_o  (clkSync),
    .rise_o  (clkRise),
    .fall_o  (clkFall)
  );

  qspi_sync_edge uCsSync (
    .clk_i   (clk_in),
    .rst_n_i (rst_n),
    .async_i (ram_cs_n),
    .sync_o  (csSync),
    .rise_o  (csRise),
    .fall_o  (csFall)
  );

  assign unusedSync = clkSync ^ csRise;

  logic [3:0] ioMeta_q;
  logic [3:0] ioSync_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ioMeta_q <= '0;
      ioSync_q <= '0;
    end else begin
      ioMeta_q <= ram_io_in;
      ioSync_q <= ioMeta_q;
    end
  end

  qspiState_e            state_q;
  logic [CNT_W-1:0]      nibCnt_q;
  logic [3:0]            cmdHi_q;
  logic                  isWrite_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [3:0]            hiNib_q;
  logic                  hiValid_q;
  logic                  lowPhase_q;
  logic [3:0]            ioOut_q;
  logic                  ioOe_q;
  logic                  cmdErr_q;
  logic                  busy_q;

  logic [7:0] mem [DEPTH];
  logic [7:0] memRdata_q;
  logic       memWe;
  logic [7:0] memWdata;
  logic [7:0] cmdByte;

  assign cmdByte  = {cmdHi_q, ioSync_q};
  assign memWe    = (state_q == ST_WRITE) && clkRise && hiValid_q && !csSync;
  assign memWdata = {hiNib_q, ioSync_q};

  // Single-port array read every cycle at addr_q, so the next read byte is
  // always ready long before the following ram_clk fall needs it.
  always_ff @(posedge clk_in) begin
    if (memWe) begin
      mem[addr_q] <= memWdata;
    end
    memRdata_q <= mem[addr_q];
  end

  // Deselect overrides every state, including a rise strobe in the same cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      nibCnt_q   <= '0;
      cmdHi_q    <= '0;
      isWrite_q  <= 1'b0;
      addr_q     <= '0;
      hiNib_q    <= '0;
      hiValid_q  <= 1'b0;
      lowPhase_q <= 1'b0;
      ioOut_q    <= '0;
      ioOe_q     <= 1'b0;
      cmdErr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cmdErr_q <= 1'b0;
      if (csSync) begin
        state_q    <= ST_IDLE;
        nibCnt_q   <= '0;
        hiValid_q  <= 1'b0;
        lowPhase_q <= 1'b0;
        ioOe_q     <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (csFall) begin
              state_q  <= ST_CMD;
              nibCnt_q <= '0;
              busy_q   <= 1'b1;
            end
          end
          ST_CMD: begin
            if (clkRise) begin
              if (nibCnt_q == '0) begin
                cmdHi_q  <= ioSync_q;
                nibCnt_q <= CNT_W'(1);
              end else begin
                nibCnt_q <= '0;
                if (isKnownCmd(cmdByte)) begin
                  state_q   <= ST_ADDR;
                  isWrite_q <= (cmdByte == CMD_WRITE_QUAD);
                end else begin
                  state_q  <= ST_IGNORE;
                  cmdErr_q <= 1'b1;
                end
              end
            end
          end
          ST_ADDR: begin
            if (clkRise) begin
              addr_q <= DEPTH_LOG2'({addr_q, ioSync_q});
              if (nibCnt_q == ADDR_LAST) begin
                nibCnt_q  <= '0;
                hiValid_q <= 1'b0;
                state_q   <= isWrite_q ? ST_WRITE : ST_DUMMY;
              end else begin
                nibCnt_q <= nibCnt_q + CNT_W'(1);
              end
            end
          end
          ST_DUMMY: begin
            if (clkRise) begin
              if (nibCnt_q == WAIT_LAST) begin
                nibCnt_q   <= '0;
                lowPhase_q <= 1'b0;
                state_q    <= ST_READ;
              end else begin
                nibCnt_q <= nibCnt_q + CNT_W'(1);
              end
            end
          end
          ST_READ: begin
            if (clkFall) begin
              ioOe_q <= 1'b1;
              if (!lowPhase_q) begin
                ioOut_q    <= memRdata_q[7:4];
                lowPhase_q <= 1'b1;
              end else begin
                ioOut_q    <= memRdata_q[3:0];
                lowPhase_q <= 1'b0;
                addr_q     <= addr_q + DEPTH_LOG2'(1);
              end
            end
          end
          ST_WRITE: begin
            if (clkRise) begin
              if (!hiValid_q) begin
                hiNib_q   <= ioSync_q;
                hiValid_q <= 1'b1;
              end else begin
                hiValid_q <= 1'b0;
                addr_q    <= addr_q + DEPTH_LOG2'(1);
              end
            end
          end
          ST_IGNORE: begin
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ram_io_out = ioOut_q;
  assign ram_io_oe  = ioOe_q;
  assign cmd_err    = cmdErr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_qspi_ram_emulator.sv
// Bench for qspi_ram_emulator: a bus master drives two instances (10 and 1 dummy
// cycles) and read data is compared with a byte-array model and fixed vectors.
module tb_qspi_ram_emulator;
  import qspi_ram_pkg::*;

  localparam int DEPTH = 4096;

  logic clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  logic       rstN;
  logic       ramClkA [2];
  logic       csNA    [2];
  logic [3:0] ioInA   [2];
  logic [3:0] ioOutA  [2];
  logic       oeA     [2];
  logic       errA    [2];
  logic       busyA   [2];

  qspi_ram_emulator #(
    .ADDR_W(24), .DEPTH_LOG2(12), .WAIT_CYCLES(10), .INIT_FILE("")
  ) dut0 (
    .clk_in(clkIn), .rst_n(rstN), .ram_clk(ramClkA[0]), .ram_cs_n(csNA[0]),
    .ram_io_in(ioInA[0]), .ram_io_out(ioOutA[0]), .ram_io_oe(oeA[0]),
    .cmd_err(errA[0]), .busy(busyA[0])
  );

  qspi_ram_emulator #(
    .ADDR_W(24), .DEPTH_LOG2(12), .WAIT_CYCLES(1), .INIT_FILE("")
  ) dut1 (
    .clk_in(clkIn), .rst_n(rstN), .ram_clk(ramClkA[1]), .ram_cs_n(csNA[1]),
    .ram_io_in(ioInA[1]), .ram_io_out(ioOutA[1]), .ram_io_oe(oeA[1]),
    .cmd_err(errA[1]), .busy(busyA[1])
  );

  // Half ram_clk period in clk_in cycles: unit 0 at clk_in/6, unit 1 at clk_in/4.
  int hOf    [2] = '{3, 2};
  int waitOf [2] = '{10, 1};

  logic [7:0] model [2][DEPTH];
  logic [7:0] wrData [$];
  logic [7:0] rdData [$];
  int checks = 0;
  int failures = 0;
  int errPulses [2] = '{0, 0};

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] expNibs;
  } vec_t;

  vec_t vecs [4];

  always @(negedge clkIn) begin
    for (int u = 0; u < 2; u++) begin
      if (errA[u] === 1'b1) errPulses[u]++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clkIn);
  endtask

  task automatic busCycle(input int u, input logic [3:0] nib);
    ramClkA[u] = 1'b0;
    ioInA[u] = nib;
    ticks(hOf[u]);
    ramClkA[u] = 1'b1;
    ticks(hOf[u]);
  endtask

  task automatic deselect(input int u);
    ramClkA[u] = 1'b0;
    ticks(hOf[u]);
    csNA[u] = 1'b1;
    ticks(6);
  endtask

  task automatic sendHeader(input int u, input logic [7:0] cmd, input logic [23:0] addr);
    csNA[u] = 1'b0;
    ticks(hOf[u]);
    busCycle(u, cmd[7:4]);
    busCycle(u, cmd[3:0]);
    for (int i = 5; i >= 0; i--) busCycle(u, addr[i*4 +: 4]);
  endtask

  task automatic writeBurst(input int u, input logic [23:0] addr, input int n);
    sendHeader(u, CMD_WRITE_QUAD, addr);
    for (int i = 0; i < n; i++) begin
      busCycle(u, wrData[i][7:4]);
      busCycle(u, wrData[i][3:0]);
      model[u][(int'(addr) + i) % DEPTH] = wrData[i];
    end
    deselect(u);
  endtask

  task automatic readBurst(input int u, input logic [23:0] addr, input int n, input string tag);
    logic [3:0] hi;
    logic oeOk;
    rdData.delete();
    oeOk = 1'b1;
    sendHeader(u, CMD_READ_QUAD, addr);
    repeat (waitOf[u]) busCycle(u, 4'h0);
    checkOutput({tag, " oe before data"}, 32'(oeA[u]), 32'd0);
    for (int i = 0; i < n; i++) begin
      busCycle(u, 4'h0);
      hi = ioOutA[u];
      oeOk = oeOk & oeA[u];
      busCycle(u, 4'h0);
      oeOk = oeOk & oeA[u];
      rdData.push_back({hi, ioOutA[u]});
      checkOutput($sformatf("%s byte%0d", tag, i), 32'(rdData[i]),
                  32'(model[u][(int'(addr) + i) % DEPTH]));
    end
    checkOutput({tag, " oe during read"}, 32'(oeOk), 32'd1);
    deselect(u);
  endtask

  task automatic applyStimulus(input vec_t v, input int k);
    wrData.delete();
    wrData.push_back(v.d0);
    wrData.push_back(v.d1);
    writeBurst(0, v.addr, 2);
    readBurst(0, v.addr, 2, $sformatf("vec%0d", k));
    checkOutput($sformatf("vec%0d nibbles", k), 32'({rdData[0], rdData[1]}), 32'(v.expNibs));
  endtask

  int errBefore;
  int upper, off, len;
  logic [23:0] ra;

  initial begin
    vecs[0] = '{24'h000010, 8'hA5, 8'h3C, 16'hA53C};
    vecs[1] = '{24'h000ABC, 8'h5A, 8'h96, 16'h5A96};
    vecs[2] = '{24'h123456, 8'hC3, 8'h7E, 16'hC37E};
    vecs[3] = '{24'h000FFF, 8'h11, 8'h22, 16'h1122};

    rstN = 1'b0;
    for (int u = 0; u < 2; u++) begin
      ramClkA[u] = 1'b0;
      csNA[u] = 1'b1;
      ioInA[u] = 4'h0;
    end
    ticks(5);
    checkOutput("reset oe", 32'(oeA[0]), 32'd0);
    checkOutput("reset io_out", 32'(ioOutA[0]), 32'd0);
    checkOutput("reset busy", 32'(busyA[0]), 32'd0);
    checkOutput("reset cmd_err", 32'(errA[0]), 32'd0);
    rstN = 1'b1;
    ticks(5);

    for (int k = 0; k < 4; k++) applyStimulus(vecs[k], k);

    readBurst(0, 24'h000000, 1, "wrap byte0");
    checkOutput("wrap mem0", 32'(rdData[0]), 32'h22);
    readBurst(0, 24'h000456, 1, "alias");
    checkOutput("alias high addr bits", 32'(rdData[0]), 32'hC3);

    errBefore = errPulses[0];
    sendHeader(0, 8'h9F, 24'h000010);
    ticks(2);
    checkOutput("unknown cmd err pulses", 32'(errPulses[0] - errBefore), 32'd1);
    checkOutput("unknown cmd busy", 32'(busyA[0]), 32'd1);
    checkOutput("unknown cmd oe", 32'(oeA[0]), 32'd0);
    deselect(0);
    checkOutput("unknown cmd busy after cs", 32'(busyA[0]), 32'd0);
    readBurst(0, 24'h000010, 2, "after unknown");
    checkOutput("after unknown data", 32'({rdData[0], rdData[1]}), 32'hA53C);

    wrData.delete();
    wrData.push_back(8'h5A);
    writeBurst(0, 24'h000020, 1);
    sendHeader(0, CMD_WRITE_QUAD, 24'h000020);
    busCycle(0, 4'hF);
    deselect(0);
    readBurst(0, 24'h000020, 1, "partial write");
    checkOutput("partial write kept", 32'(rdData[0]), 32'h5A);

    sendHeader(0, CMD_READ_QUAD, 24'h000010);
    repeat (waitOf[0]) busCycle(0, 4'h0);
    busCycle(0, 4'h0);
    checkOutput("mid-read oe", 32'(oeA[0]), 32'd1);
    checkOutput("mid-read first nibble", 32'(ioOutA[0]), 32'hA);
    csNA[0] = 1'b1;
    ticks(4);
    checkOutput("deselect drops oe", 32'(oeA[0]), 32'd0);
    checkOutput("deselect clears busy", 32'(busyA[0]), 32'd0);
    ramClkA[0] = 1'b0;
    ticks(6);

    sendHeader(0, CMD_READ_QUAD, 24'h000010);
    repeat (waitOf[0]) busCycle(0, 4'h0);
    busCycle(0, 4'h0);
    rstN = 1'b0;
    ticks(1);
    rstN = 1'b1;
    ticks(1);
    checkOutput("mid-read reset oe", 32'(oeA[0]), 32'd0);
    checkOutput("mid-read reset io_out", 32'(ioOutA[0]), 32'd0);
    checkOutput("mid-read reset busy", 32'(busyA[0]), 32'd0);
    checkOutput("mid-read reset cmd_err", 32'(errA[0]), 32'd0);
    ticks(4);
    checkOutput("post-reset busy stays low", 32'(busyA[0]), 32'd0);
    deselect(0);
    readBurst(0, 24'h000010, 2, "after reset");
    checkOutput("after reset data", 32'({rdData[0], rdData[1]}), 32'hA53C);

    wrData.delete();
    for (int i = 0; i < 64; i++) wrData.push_back(8'($urandom));
    writeBurst(0, 24'h000100, 64);
    for (int t = 0; t < 20; t++) begin
      upper = $urandom_range(0, 4095);
      if ($urandom_range(0, 1) == 1) begin
        len = $urandom_range(1, 4);
        off = $urandom_range(0, 64 - len);
        ra = 24'((upper << 12) | (256 + off));
        wrData.delete();
        for (int i = 0; i < len; i++) wrData.push_back(8'($urandom));
        writeBurst(0, ra, len);
      end
      len = $urandom_range(1, 6);
      off = $urandom_range(0, 64 - len);
      ra = 24'((upper << 12) | (256 + off));
      readBurst(0, ra, len, $sformatf("rand%0d", t));
    end

    wrData.delete();
    for (int i = 0; i < 16; i++) wrData.push_back(8'($urandom));
    writeBurst(1, 24'h000FF8, 16);
    readBurst(1, 24'h000FF8, 16, "fast burst");
    checkOutput("fast burst wrapped byte", 32'(rdData[8]), 32'(wrData[8]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
